sha256_nonce_sched: RTL and testbench
=====================================

SHA256_NONCE_SCHED -- requirements
Module: sha256_nonce_sched

Interface
REQ-001 The block SHALL have parameter WDOG_CYCLES, default 4096, giving the maximum number of cycles to wait for sha_ready after sha_start.
REQ-002 The block SHALL have these ports, and no others:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- job_valid  input  1  new job offered.
- job_ready  output  1  block idle and able to accept a job.
- job_header  input  608  first 76 header bytes, byte 0 in MSBs.
- job_target  input  256  target; a hash is a hit when hash < target.
- nonce_first  input  32  first nonce to try.
- nonce_last  input  32  last nonce to try, inclusive.
- abort  input  1  cancel the current job.
- sha_start  output  1  one-cycle start pulse to the SHA-256 core.
- sha_data  output  640  message to the core.
- sha_ready  input  1  one-cycle done pulse from the core.
- sha_hash  input  256  digest; valid while sha_ready=1.
- found_valid  output  1  winning nonce available.
- found_nonce  output  32  winning nonce.
- found_ready  input  1  consumer accepts found_nonce.
- exhausted  output  1  one-cycle pulse; the range is finished.
- sha_fault  output  1  sticky; a watchdog expiry occurred in this job.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, COMPARE, REPORT, and ISSUE2/WAIT2 when double hashing is enabled.
REQ-004 In IDLE, job_ready SHALL be 1. When job_valid=1, the block SHALL latch header, target, nonce_first and nonce_last, set nonce=nonce_first, clear sha_fault and go to ISSUE. job_ready SHALL be 0 in every other state.
REQ-005 ISSUE SHALL assert sha_start for exactly one cycle with sha_data={job_header, nonce}, then go to WAIT.
REQ-006 WAIT SHALL sample sha_ready from the cycle after ISSUE. On sha_ready, the block SHALL latch sha_hash as digest and go to COMPARE, or to ISSUE2 when double hashing is enabled. sha_ready in any other state SHALL be ignored.
REQ-007 Watchdog: a counter SHALL clear on every sha_start. If WDOG_CYCLES cycles elapse in WAIT or WAIT2 without sha_ready, the block SHALL set sha_fault and re-issue the same pass with the same nonce. Retries SHALL be unlimited.
REQ-008 COMPARE SHALL be one cycle and SHALL use an unsigned 256-bit strict less-than of digest against target:
- hit: go to REPORT.
- miss with nonce==nonce_last: pulse exhausted, go to IDLE.
- otherwise: nonce<=nonce+1, go to ISSUE.
REQ-009 REPORT SHALL hold found_valid=1 with found_nonce stable until found_ready=1 is sampled. It SHALL then apply the miss rules of REQ-008, so the search continues after a hit.
REQ-010 The nonce SHALL increment modulo 2^32. If nonce_last < nonce_first, the search SHALL wrap from 0xFFFFFFFF to 0x00000000 and stop after nonce_last.
REQ-011 nonce_first==nonce_last SHALL give exactly one hash attempt.
REQ-012 When abort=1 in any non-IDLE state, the next state SHALL be IDLE. In that next cycle, found_valid and sha_start SHALL be 0 and no exhausted pulse SHALL occur.
REQ-013 abort SHALL win over a simultaneous sha_ready, found_ready or watchdog expiry. abort in IDLE SHALL be ignored.
REQ-014 Throughput: the single-hash loop SHALL be ISSUE→WAIT→COMPARE, i.e. core latency plus 2 cycles per nonce.

Reset
REQ-015 While reset=0, the block SHALL be in IDLE with job_ready=1. sha_start, found_valid, exhausted and sha_fault SHALL be 0; found_nonce, nonce and sha_data SHALL be 0; the watchdog SHALL be 0.
REQ-016 Reset in the middle of a job SHALL discard the job with no exhausted or found output. The first job SHALL be accepted in the first cycle after reset is released.

Configuration
REQ-017 Macro MINER_DOUBLE_SHA_EN SHALL select double hashing.
- Defined: after WAIT, ISSUE2 SHALL pulse sha_start with sha_data={digest, 384'h0}. WAIT2 SHALL follow the REQ-006 and REQ-007 rules and latch the second digest for COMPARE.
- Undefined: ISSUE2 and WAIT2 SHALL not exist, and the single SHA-256 digest SHALL be compared.

Verification
REQ-018 Scenario single hit: nonce_first=5, nonce_last=5, stub core returns 0 for nonce 5 with target 1 → found_valid with found_nonce=5; on found_ready, one exhausted pulse, then IDLE.
REQ-019 Scenario range miss: range 0..3, stub hash all-ones, target 1 → 4 sha_start pulses with nonces 0,1,2,3, then exhausted, and found_valid never asserted.
REQ-020 Scenario wrap: nonce_first=0xFFFFFFFE, nonce_last=0x00000001 → nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001, then exhausted.
REQ-021 Scenario watchdog: WDOG_CYCLES=8, stub drops the first sha_ready → sha_fault=1 and sha_start re-pulses with the same nonce 8 cycles after the first.
REQ-022 Scenario abort: assert abort in the same cycle as sha_ready for a hit → next cycle IDLE with job_ready=1, and found_valid and exhausted stay 0.
REQ-023 Scenario double hash: with MINER_DOUBLE_SHA_EN defined, the second sha_data equals {first digest, 384'h0}, and exactly 2 sha_start pulses occur per nonce.

Source files
------------

// File: rtl/sha256_nonce_sched.sv
// Nonce search scheduler: feeds {header, nonce} to an external SHA-256 core and reports digests below target.
// Define MINER_DOUBLE_SHA_EN to hash every digest a second time (SHA-256d) before comparing.
module sha256_nonce_sched #(
    parameter int WDOG_CYCLES = 4096  // must be >= 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [607:0] job_header,
    input  logic [255:0] job_target,
    input  logic [31:0]  nonce_first,
    input  logic [31:0]  nonce_last,
    input  logic         abort,
    output logic         sha_start,
    output logic [639:0] sha_data,
    input  logic         sha_ready,
    input  logic [255:0] sha_hash,
    output logic         found_valid,
    output logic [31:0]  found_nonce,
    input  logic         found_ready,
    output logic         exhausted,
    output logic         sha_fault
);

    // Handshakes: a job transfers on job_valid & job_ready; a winning nonce transfers
    // on found_valid & found_ready; sha_start/sha_ready/exhausted are single-cycle pulses.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPARE,
        S_REPORT
`ifdef MINER_DOUBLE_SHA_EN
        , S_ISSUE2,
        S_WAIT2
`endif
    } state_t;

    // r_wdog counts cycles since the last sha_start; expiry lands the re-issue WDOG_CYCLES after it.
    localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES - 2);

    state_t         r_state;
    state_t         w_next;
    logic [607:0]   r_header;
    logic [255:0]   r_target;
    logic [31:0]    r_nonce;
    logic [31:0]    r_last;
    logic [255:0]   r_digest;
    logic [31:0]    r_wdog;
    logic           r_fault;
    logic           r_exhausted;

    logic           w_hit;
    logic           w_at_last;
    logic           w_wdog_exp;
    logic           w_ld_job;
    logic           w_take_digest;
    logic           w_advance;
    logic           w_finish;
    logic           w_fault_set;
    logic           w_in_wait;

    assign w_hit      = r_digest < r_target;
    assign w_at_last  = r_nonce == r_last;
    assign w_wdog_exp = r_wdog >= WDOG_LIMIT;

    always_comb begin
        w_next        = r_state;
        w_ld_job      = 1'b0;
        w_take_digest = 1'b0;
        w_advance     = 1'b0;
        w_finish      = 1'b0;
        w_fault_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_valid) begin
                    w_ld_job = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (sha_ready) begin
                    w_take_digest = 1'b1;
`ifdef MINER_DOUBLE_SHA_EN
                    w_next        = S_ISSUE2;
`else
                    w_next        = S_COMPARE;
`endif
                end else if (w_wdog_exp) begin
                    w_fault_set = 1'b1;
                    w_next      = S_ISSUE;
                end
            end
`ifdef MINER_DOUBLE_SHA_EN
            S_ISSUE2: w_next = S_WAIT2;
            S_WAIT2: begin
                if (sha_ready) begin
                    w_take_digest = 1'b1;
                    w_next        = S_COMPARE;
                end else if (w_wdog_exp) begin
                    w_fault_set = 1'b1;
                    w_next      = S_ISSUE2;
                end
            end
`endif
            S_COMPARE: begin
                if (w_hit) begin
                    w_next = S_REPORT;
                end else if (w_at_last) begin
                    w_finish = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_advance = 1'b1;
                    w_next    = S_ISSUE;
                end
            end
            S_REPORT: begin
                // After the consumer takes the nonce the search resumes as if it were a miss.
                if (found_ready) begin
                    if (w_at_last) begin
                        w_finish = 1'b1;
                        w_next   = S_IDLE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = S_ISSUE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase

        if (abort && r_state != S_IDLE) begin
            w_next        = S_IDLE;
            w_take_digest = 1'b0;
            w_advance     = 1'b0;
            w_finish      = 1'b0;
            w_fault_set   = 1'b0;
        end
    end

    always_comb begin
        w_in_wait = r_state == S_WAIT;
`ifdef MINER_DOUBLE_SHA_EN
        w_in_wait = w_in_wait || r_state == S_WAIT2;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_header    <= '0;
            r_target    <= '0;
            r_nonce     <= '0;
            r_last      <= '0;
            r_digest    <= '0;
            r_wdog      <= '0;
            r_fault     <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_exhausted <= w_finish;
            if (w_ld_job) begin
                r_header <= job_header;
                r_target <= job_target;
                r_nonce  <= nonce_first;
                r_last   <= nonce_last;
                r_fault  <= 1'b0;
            end else if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            if (w_advance) begin
                r_nonce <= r_nonce + 32'd1;
            end
            if (w_take_digest) begin
                r_digest <= sha_hash;
            end
            if (sha_start) begin
                r_wdog <= '0;
            end else if (w_in_wait) begin
                r_wdog <= r_wdog + 32'd1;
            end
        end
    end

    always_comb begin
        sha_start = r_state == S_ISSUE;
        sha_data  = {r_header, r_nonce};
`ifdef MINER_DOUBLE_SHA_EN
        if (r_state == S_ISSUE2) begin
            sha_start = 1'b1;
            sha_data  = {r_digest, 384'h0};
        end
`endif
    end

    assign job_ready   = r_state == S_IDLE;
    assign found_valid = r_state == S_REPORT;
    assign found_nonce = r_nonce;
    assign exhausted   = r_exhausted;
    assign sha_fault   = r_fault;

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Bench for sha256_nonce_sched: stub SHA core with controllable latency/drops, and a range-walking reference model.
module tb_sha256_nonce_sched;

    localparam int WDOG = 8;
`ifdef MINER_DOUBLE_SHA_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [607:0] job_header;
    logic [255:0] job_target;
    logic [31:0]  nonce_first;
    logic [31:0]  nonce_last;
    logic         abort;
    logic         abort_main;
    logic         abort_core;
    logic         sha_start;
    logic [639:0] sha_data;
    logic         sha_ready;
    logic [255:0] sha_hash;
    logic         found_valid;
    logic [31:0]  found_nonce;
    logic         found_ready;
    logic         exhausted;
    logic         sha_fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // stub core controls and logs
    int           hash_mode;
    logic [31:0]  hit_key;
    int           core_lat;
    int           drop_n;
    int           abort_on_ready;
    int           ready_n;
    logic [639:0] start_q[$];
    int           start_cyc_q[$];

    // scoreboard
    logic [31:0]  exp_try_q[$];
    logic [31:0]  exp_hit_q[$];
    logic [31:0]  got_found_q[$];
    int           got_exh;
    bit           timed_out;
    bit           found_unstable;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign abort = abort_main | abort_core;

    sha256_nonce_sched #(.WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_header(job_header),
        .job_target(job_target), .nonce_first(nonce_first), .nonce_last(nonce_last),
        .abort(abort), .sha_start(sha_start), .sha_data(sha_data),
        .sha_ready(sha_ready), .sha_hash(sha_hash),
        .found_valid(found_valid), .found_nonce(found_nonce), .found_ready(found_ready),
        .exhausted(exhausted), .sha_fault(sha_fault)
    );

    function automatic logic [255:0] stub_hash(input logic [639:0] d);
        logic [31:0] a;
        case (hash_mode)
            0: return {256{1'b1}};
            1: return (d[31:0] == hit_key || d == 640'h0) ? 256'h0 : {256{1'b1}};
            default: begin
                a = (d[31:0] ^ d[639:608]) * 32'h9E3779B1 + d[415:384];
                return {a, {7{a ^ 32'hC3A55A3C}}};
            end
        endcase
    endfunction

    function automatic logic [255:0] final_digest(input logic [607:0] hdr, input logic [31:0] n);
        logic [255:0] d;
        d = stub_hash({hdr, n});
`ifdef MINER_DOUBLE_SHA_EN
        d = stub_hash({d, 384'h0});
`endif
        return d;
    endfunction

    // Stub SHA core: one outstanding request, answers core_lat cycles later (random 1..5 when 0).
    initial begin
        bit           pend;
        int           cnt;
        logic [255:0] pend_hash;
        pend = 0; cnt = 0; pend_hash = '0;
        sha_ready = 1'b0; sha_hash = '0; abort_core = 1'b0;
        forever begin
            @(negedge clk);
            sha_ready  = 1'b0;
            abort_core = 1'b0;
            if (!reset) begin
                pend = 0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 0;
                    if (drop_n > 0) begin
                        drop_n--;
                    end else begin
                        sha_ready = 1'b1;
                        sha_hash  = pend_hash;
                        ready_n++;
                        if (abort_on_ready != 0 && ready_n == abort_on_ready) begin
                            abort_core     = 1'b1;
                            abort_on_ready = 0;
                        end
                    end
                end
            end
            if (reset && sha_start) begin
                start_q.push_back(sha_data);
                start_cyc_q.push_back(cyc);
                pend      = 1;
                cnt       = (core_lat != 0) ? core_lat : int'($urandom_range(1, 5));
                pend_hash = stub_hash(sha_data);
            end
        end
    end

    function automatic logic [607:0] rand_header();
        logic [607:0] h;
        for (int i = 0; i < 19; i++) h[i*32 +: 32] = $urandom;
        h[607] = 1'b1;
        return h;
    endfunction

    task automatic build_model(input logic [607:0] hdr, input logic [255:0] tgt,
                               input logic [31:0] first, input logic [31:0] last);
        logic [31:0] n;
        exp_try_q.delete();
        exp_hit_q.delete();
        n = first;
        for (int k = 0; k < 4096; k++) begin
            exp_try_q.push_back(n);
            if (final_digest(hdr, n) < tgt) exp_hit_q.push_back(n);
            if (n == last) break;
            n = n + 32'd1;
        end
    endtask

    // Offers one job and collects found nonces, exhausted pulses and core starts until the job ends.
    task automatic run_job(input logic [607:0] hdr, input logic [255:0] tgt,
                           input logic [31:0] first, input logic [31:0] last, input int budget);
        int          wait_n;
        bit          in_rep;
        bit          done;
        logic [31:0] held;
        got_found_q.delete();
        start_q.delete();
        start_cyc_q.delete();
        got_exh = 0; timed_out = 0; found_unstable = 0; ready_n = 0;
        wait_n = 0; in_rep = 0; done = 0; held = '0;
        for (int i = 0; i < 50 && job_ready !== 1'b1; i++) @(negedge clk);
        job_header = hdr; job_target = tgt; nonce_first = first; nonce_last = last;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            found_ready = 1'b0;
            if (exhausted) begin
                got_exh++;
                done = 1;
            end
            if (found_valid) begin
                if (!in_rep) begin
                    in_rep = 1;
                    held   = found_nonce;
                    wait_n = $urandom_range(0, 3);
                end else if (found_nonce !== held) begin
                    found_unstable = 1;
                end
                if (wait_n == 0) begin
                    found_ready = 1'b1;
                    got_found_q.push_back(found_nonce);
                    in_rep = 0;
                end else begin
                    wait_n--;
                end
            end
            if (!done) @(negedge clk);
        end
        if (!done) timed_out = 1;
        found_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (exhausted) got_exh++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; job_valid = 1'b0; job_header = '0; job_target = '0;
        nonce_first = '0; nonce_last = '0; abort_main = 1'b0; found_ready = 1'b0;
        hash_mode = 0; hit_key = '0; core_lat = 3; drop_n = 0; abort_on_ready = 0; ready_n = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (job_ready !== 1'b1) begin n_errors++; $display("FAIL reset_job_ready got=%b exp=1", job_ready); end
        n_checks++;
        if ({sha_start, found_valid, exhausted, sha_fault} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_pulses got=%b exp=0000", {sha_start, found_valid, exhausted, sha_fault});
        end
        n_checks++;
        if (found_nonce !== 32'h0) begin n_errors++; $display("FAIL reset_found_nonce got=%h exp=0", found_nonce); end
        n_checks++;
        if (sha_data !== 640'h0) begin n_errors++; $display("FAIL reset_sha_data got=%h exp=0", sha_data[31:0]); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_hit();
        logic [607:0] hdr;
        logic [639:0] sd;
        hdr = rand_header();
        hash_mode = 1; hit_key = 32'd5; core_lat = 0;
        run_job(hdr, 256'd1, 32'd5, 32'd5, 200);
        n_checks++;
        if (timed_out) begin n_errors++; $display("FAIL hit_timeout got=1 exp=0"); end
        n_checks++;
        if (got_found_q.size() != 1) begin n_errors++; $display("FAIL hit_count got=%0d exp=1", got_found_q.size()); end
        else begin
            n_checks++;
            if (got_found_q[0] !== 32'd5) begin n_errors++; $display("FAIL hit_nonce got=%h exp=5", got_found_q[0]); end
        end
        n_checks++;
        if (got_exh != 1) begin n_errors++; $display("FAIL hit_exhausted got=%0d exp=1", got_exh); end
        n_checks++;
        if (start_q.size() != PASSES) begin n_errors++; $display("FAIL hit_starts got=%0d exp=%0d", start_q.size(), PASSES); end
        else begin
            sd = start_q[0];
            n_checks++;
            if (sd !== {hdr, 32'd5}) begin n_errors++; $display("FAIL hit_data got=%h exp=5", sd[31:0]); end
`ifdef MINER_DOUBLE_SHA_EN
            sd = start_q[1];
            n_checks++;
            if (sd !== 640'h0) begin n_errors++; $display("FAIL hit_pass2_data got=%h exp=0", sd[639:608]); end
`endif
        end
        n_checks++;
        if (job_ready !== 1'b1) begin n_errors++; $display("FAIL hit_idle got=%b exp=1", job_ready); end
    endtask

    task automatic test_range_miss_wrap();
        logic [31:0]  t_first[2];
        logic [31:0]  t_last[2];
        logic [607:0] hdr;
        logic [639:0] sd;
        int           gap;
        t_first[0] = 32'h0;        t_last[0] = 32'h3;
        t_first[1] = 32'hFFFFFFFE; t_last[1] = 32'h1;
        hash_mode = 0; core_lat = 3;
        for (int j = 0; j < 2; j++) begin
            hdr = rand_header();
            build_model(hdr, 256'd1, t_first[j], t_last[j]);
            run_job(hdr, 256'd1, t_first[j], t_last[j], 400);
            n_checks++;
            if (timed_out) begin n_errors++; $display("FAIL range%0d_timeout got=1 exp=0", j); end
            n_checks++;
            if (got_exh != 1) begin n_errors++; $display("FAIL range%0d_exhausted got=%0d exp=1", j, got_exh); end
            n_checks++;
            if (got_found_q.size() != 0) begin n_errors++; $display("FAIL range%0d_found got=%0d exp=0", j, got_found_q.size()); end
            n_checks++;
            if (start_q.size() != PASSES * exp_try_q.size()) begin
                n_errors++; $display("FAIL range%0d_starts got=%0d exp=%0d", j, start_q.size(), PASSES * exp_try_q.size());
            end else begin
                for (int i = 0; i < exp_try_q.size(); i++) begin
                    sd = start_q[i*PASSES];
                    n_checks++;
                    if (sd !== {hdr, exp_try_q[i]}) begin
                        n_errors++; $display("FAIL range%0d_nonce%0d got=%h exp=%h", j, i, sd[31:0], exp_try_q[i]);
                    end
                    if (i > 0) begin
                        gap = start_cyc_q[i*PASSES] - start_cyc_q[(i-1)*PASSES];
                        n_checks++;
                        if (gap != PASSES * (core_lat + 1) + 1) begin
                            n_errors++; $display("FAIL range%0d_period%0d got=%0d exp=%0d", j, i, gap, PASSES * (core_lat + 1) + 1);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_random_jobs();
        logic [607:0] hdr;
        logic [255:0] tgt;
        logic [31:0]  first;
        logic [31:0]  last;
        logic [639:0] sd;
        hash_mode = 2; core_lat = 0;
        for (int j = 0; j < 6; j++) begin
            hdr   = rand_header();
            tgt   = {32'($urandom_range(0, 32'h40000000)), {7{32'($urandom)}}};
            first = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF - 32'($urandom_range(0, 5)) : $urandom;
            last  = first + 32'($urandom_range(0, 10));
            build_model(hdr, tgt, first, last);
            run_job(hdr, tgt, first, last, 2000);
            n_checks++;
            if (timed_out) begin n_errors++; $display("FAIL rand%0d_timeout got=1 exp=0", j); end
            n_checks++;
            if (got_exh != 1) begin n_errors++; $display("FAIL rand%0d_exhausted got=%0d exp=1", j, got_exh); end
            n_checks++;
            if (found_unstable) begin n_errors++; $display("FAIL rand%0d_found_stable got=1 exp=0", j); end
            n_checks++;
            if (got_found_q.size() != exp_hit_q.size()) begin
                n_errors++; $display("FAIL rand%0d_hits got=%0d exp=%0d", j, got_found_q.size(), exp_hit_q.size());
            end else begin
                for (int i = 0; i < exp_hit_q.size(); i++) begin
                    n_checks++;
                    if (got_found_q[i] !== exp_hit_q[i]) begin
                        n_errors++; $display("FAIL rand%0d_hit%0d got=%h exp=%h", j, i, got_found_q[i], exp_hit_q[i]);
                    end
                end
            end
            n_checks++;
            if (start_q.size() != PASSES * exp_try_q.size()) begin
                n_errors++; $display("FAIL rand%0d_starts got=%0d exp=%0d", j, start_q.size(), PASSES * exp_try_q.size());
            end else begin
                for (int i = 0; i < exp_try_q.size(); i++) begin
                    sd = start_q[i*PASSES];
                    n_checks++;
                    if (sd !== {hdr, exp_try_q[i]}) begin
                        n_errors++; $display("FAIL rand%0d_data%0d got=%h exp=%h", j, i, sd[31:0], exp_try_q[i]);
                    end
`ifdef MINER_DOUBLE_SHA_EN
                    sd = start_q[i*PASSES+1];
                    n_checks++;
                    if (sd !== {stub_hash({hdr, exp_try_q[i]}), 384'h0}) begin
                        n_errors++; $display("FAIL rand%0d_pass2_%0d got=%h", j, i, sd[639:608]);
                    end
`endif
                end
            end
        end
    endtask

    task automatic test_watchdog();
        logic [607:0] hdr;
        logic [639:0] sd0;
        logic [639:0] sd1;
        hdr = rand_header();
        hash_mode = 0; core_lat = 2; drop_n = 1;
        run_job(hdr, 256'd1, 32'd7, 32'd7, 300);
        drop_n = 0;
        n_checks++;
        if (timed_out) begin n_errors++; $display("FAIL wdog_timeout got=1 exp=0"); end
        n_checks++;
        if (sha_fault !== 1'b1) begin n_errors++; $display("FAIL wdog_fault got=%b exp=1", sha_fault); end
        n_checks++;
        if (start_q.size() != PASSES + 1) begin
            n_errors++; $display("FAIL wdog_starts got=%0d exp=%0d", start_q.size(), PASSES + 1);
        end else begin
            sd0 = start_q[0];
            sd1 = start_q[1];
            n_checks++;
            if (sd1 !== sd0) begin n_errors++; $display("FAIL wdog_same_nonce got=%h exp=%h", sd1[31:0], sd0[31:0]); end
            n_checks++;
            if (start_cyc_q[1] - start_cyc_q[0] != WDOG) begin
                n_errors++; $display("FAIL wdog_delay got=%0d exp=%0d", start_cyc_q[1] - start_cyc_q[0], WDOG);
            end
        end
        n_checks++;
        if (got_exh != 1) begin n_errors++; $display("FAIL wdog_exhausted got=%0d exp=1", got_exh); end
        run_job(hdr, 256'd1, 32'd8, 32'd8, 300);
        n_checks++;
        if (sha_fault !== 1'b0) begin n_errors++; $display("FAIL wdog_fault_clear got=%b exp=0", sha_fault); end
    endtask

    task automatic test_abort();
        bit seen;
        bit bad;
        hash_mode = 1; hit_key = 32'd9; core_lat = 2; ready_n = 0; abort_on_ready = PASSES;
        for (int i = 0; i < 50 && job_ready !== 1'b1; i++) @(negedge clk);
        job_header = rand_header(); job_target = 256'd1; nonce_first = 32'd9; nonce_last = 32'd9;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (abort) seen = 1;
        end
        abort_on_ready = 0;
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL abort_trigger got=0 exp=1"); end
        @(negedge clk);
        n_checks++;
        if (job_ready !== 1'b1) begin n_errors++; $display("FAIL abort_idle got=%b exp=1", job_ready); end
        n_checks++;
        if ({found_valid, sha_start, exhausted} !== 3'b000) begin
            n_errors++; $display("FAIL abort_outputs got=%b exp=000", {found_valid, sha_start, exhausted});
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (found_valid || exhausted) bad = 1;
        end
        n_checks++;
        if (bad) begin n_errors++; $display("FAIL abort_quiet got=1 exp=0"); end

        // abort while idle must not block a job offered in the same cycle
        hash_mode = 0; core_lat = 4;
        nonce_first = 32'd20; nonce_last = 32'd20;
        abort_main = 1'b1; job_valid = 1'b1;
        @(negedge clk);
        abort_main = 1'b0; job_valid = 1'b0;
        n_checks++;
        if (sha_start !== 1'b1) begin n_errors++; $display("FAIL abort_idle_ignored got=%b exp=1", sha_start); end
        @(negedge clk);
        abort_main = 1'b1;
        @(negedge clk);
        abort_main = 1'b0;
        n_checks++;
        if ({job_ready, exhausted} !== 2'b10) begin
            n_errors++; $display("FAIL abort_wait got=%b exp=10", {job_ready, exhausted});
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        logic [607:0] hdr;
        hash_mode = 0; core_lat = 3;
        for (int i = 0; i < 50 && job_ready !== 1'b1; i++) @(negedge clk);
        job_header = rand_header(); job_target = 256'd1; nonce_first = 32'd0; nonce_last = 32'd40;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({job_ready, sha_start, found_valid, exhausted, sha_fault} !== 5'b10000) begin
            n_errors++; $display("FAIL midreset_ctrl got=%b exp=10000", {job_ready, sha_start, found_valid, exhausted, sha_fault});
        end
        n_checks++;
        if (found_nonce !== 32'h0 || sha_data !== 640'h0) begin
            n_errors++; $display("FAIL midreset_data got=%h/%h exp=0/0", found_nonce, sha_data[31:0]);
        end
        @(negedge clk);
        hdr = rand_header();
        job_header = hdr; nonce_first = 32'd3; nonce_last = 32'd3; job_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        n_checks++;
        if (sha_start !== 1'b1 || sha_data !== {hdr, 32'd3}) begin
            n_errors++; $display("FAIL midreset_first_job got=%b/%h exp=1/3", sha_start, sha_data[31:0]);
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_range_miss_wrap();
        test_random_jobs();
        test_watchdog();
        test_abort();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
